// File: rtl/conv_layer_ctrl_if.sv
// Handshake and strobe bundle between the conv layer sequencer and the
// host, weight loader, input buffer, conv33 core and output writer.
// The master modport is the sequencer side; slave is its environment.
interface conv_layer_ctrl_if #(
  parameter int IN_CH   = 4,
  parameter int OUT_CH  = 8,
  parameter int NUM_POS = 16
);
  localparam int ICW = (IN_CH   > 1) ? $clog2(IN_CH)   : 1;
  localparam int OCW = (OUT_CH  > 1) ? $clog2(OUT_CH)  : 1;
  localparam int PW  = (NUM_POS > 1) ? $clog2(NUM_POS) : 1;

  // requests and handshakes into the sequencer
  logic           start;
  logic           weight_load_done;
  logic           input_ready;
  logic           calc_valid;
  logic           output_done;

  // status, strobes and loop indices out of the sequencer
  logic           busy;
  logic           done;
  logic           error;
  logic           load_weight_en;
  logic           read_weight_en;
  logic           inputbuf_read_en;
  logic           conv33_en;
  logic           acc_clear;
  logic           acc_last;
  logic           output_en;
  logic [OCW-1:0] oc_idx;
  logic [PW-1:0]  pos_idx;
  logic [ICW-1:0] ic_idx;

  modport master (
    input  start, weight_load_done, input_ready, calc_valid, output_done,
    output busy, done, error, load_weight_en, read_weight_en,
           inputbuf_read_en, conv33_en, acc_clear, acc_last, output_en,
           oc_idx, pos_idx, ic_idx
  );

  modport slave (
    output start, weight_load_done, input_ready, calc_valid, output_done,
    input  busy, done, error, load_weight_en, read_weight_en,
           inputbuf_read_en, conv33_en, acc_clear, acc_last, output_en,
           oc_idx, pos_idx, ic_idx
  );
endinterface

// File: rtl/conv_layer_ctrl.sv
// Layer-level sequencer for the 3x3 convolution datapath.
// Loop order: output channel (outer), output position, input channel (inner).
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   S_IDLE    | waiting for start; indices held at 0
//   S_LOAD_W  | weight bank for oc_idx being loaded
//   S_LOAD_I  | fetching input window for (pos_idx, ic_idx)
//   S_COMPUTE | single-cycle conv33 trigger
//   S_WAIT    | waiting for the conv33 result
//   S_OUTPUT  | handing the finished pixel to the output writer
//   S_DONE    | one-cycle completion pulse, then back to idle
//
// The watchdog counts cycles spent in the four wait states and aborts to
// idle with a sticky error once TIMEOUT cycles pass with no progress.
// An exit arriving on the last permitted cycle still wins.
module conv_layer_ctrl #(
  parameter int IN_CH   = 4,
  parameter int OUT_CH  = 8,
  parameter int NUM_POS = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst,
  conv_layer_ctrl_if.master bus
);

  localparam int ICW = (IN_CH   > 1) ? $clog2(IN_CH)   : 1;
  localparam int OCW = (OUT_CH  > 1) ? $clog2(OUT_CH)  : 1;
  localparam int PW  = (NUM_POS > 1) ? $clog2(NUM_POS) : 1;
  localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam bit             WD_EN    = (TIMEOUT > 0);
  localparam logic [ICW-1:0] IC_LAST  = ICW'(IN_CH - 1);
  localparam logic [OCW-1:0] OC_LAST  = OCW'(OUT_CH - 1);
  localparam logic [PW-1:0]  POS_LAST = PW'(NUM_POS - 1);
  // watchdog fires at the end of the TIMEOUT-th cycle spent in one state
  localparam logic [WDW-1:0] WD_LAST  = (TIMEOUT > 0) ? WDW'(TIMEOUT - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_W  = 3'd1,
    S_LOAD_I  = 3'd2,
    S_COMPUTE = 3'd3,
    S_WAIT    = 3'd4,
    S_OUTPUT  = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  state_t          state, state_nxt;
  logic [OCW-1:0]  oc_q, oc_nxt;
  logic [PW-1:0]   pos_q, pos_nxt;
  logic [ICW-1:0]  ic_q, ic_nxt;
  logic            err_q, err_nxt;
  logic [WDW-1:0]  wd_cnt;
  logic            wd_hit;
  logic            abort;
  logic            in_wait_state;

  assign in_wait_state = (state == S_LOAD_W) || (state == S_LOAD_I) ||
                         (state == S_WAIT)   || (state == S_OUTPUT);

  // next-state, loop-index and error-flag logic
  always_comb begin
    state_nxt = state;
    oc_nxt    = oc_q;
    pos_nxt   = pos_q;
    ic_nxt    = ic_q;
    err_nxt   = err_q;
    abort     = 1'b0;
    wd_hit    = WD_EN && (wd_cnt == WD_LAST);

    case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_nxt = S_LOAD_W;
          err_nxt   = 1'b0;
          oc_nxt    = '0;
          pos_nxt   = '0;
          ic_nxt    = '0;
        end
      end
      S_LOAD_W: begin
        if (bus.weight_load_done) state_nxt = S_LOAD_I;
        else                      abort     = wd_hit;
      end
      S_LOAD_I: begin
        if (bus.input_ready) state_nxt = S_COMPUTE;
        else                 abort     = wd_hit;
      end
      S_COMPUTE: begin
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (bus.calc_valid) begin
          if (ic_q < IC_LAST) begin
            ic_nxt    = ic_q + ICW'(1);
            state_nxt = S_LOAD_I;
          end else begin
            ic_nxt    = '0;
            state_nxt = S_OUTPUT;
          end
        end else begin
          abort = wd_hit;
        end
      end
      S_OUTPUT: begin
        if (bus.output_done) begin
          if (pos_q < POS_LAST) begin
            pos_nxt   = pos_q + PW'(1);
            state_nxt = S_LOAD_I;
          end else begin
            pos_nxt = '0;
            if (oc_q < OC_LAST) begin
              oc_nxt    = oc_q + OCW'(1);
              state_nxt = S_LOAD_W;
            end else begin
              state_nxt = S_DONE;
            end
          end
        end else begin
          abort = wd_hit;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
        oc_nxt    = '0;
        pos_nxt   = '0;
        ic_nxt    = '0;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    if (abort) begin
      state_nxt = S_IDLE;
      err_nxt   = 1'b1;
      oc_nxt    = '0;
      pos_nxt   = '0;
      ic_nxt    = '0;
    end
  end

  // state, loop indices and sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      oc_q  <= '0;
      pos_q <= '0;
      ic_q  <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      oc_q  <= oc_nxt;
      pos_q <= pos_nxt;
      ic_q  <= ic_nxt;
      err_q <= err_nxt;
    end
  end

  // watchdog: restarts on every state change, counts only in wait states
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt <= '0;
    end else if (state_nxt != state) begin
      wd_cnt <= '0;
    end else if (WD_EN && in_wait_state) begin
      wd_cnt <= wd_cnt + WDW'(1);
    end
  end

  // Moore strobe decode; read_weight_en additionally gates on the loader
  always_comb begin
    bus.busy             = (state != S_IDLE);
    bus.done             = (state == S_DONE);
    bus.load_weight_en   = (state == S_LOAD_W);
    bus.read_weight_en   = (state == S_LOAD_W) && bus.weight_load_done;
    bus.inputbuf_read_en = (state == S_LOAD_I);
    bus.conv33_en        = (state == S_COMPUTE);
    bus.acc_clear        = (state == S_COMPUTE) && (ic_q == '0);
    bus.acc_last         = (state == S_COMPUTE) && (ic_q == IC_LAST);
    bus.output_en        = (state == S_OUTPUT);
  end

  assign bus.error   = err_q;
  assign bus.oc_idx  = oc_q;
  assign bus.pos_idx = pos_q;
  assign bus.ic_idx  = ic_q;

endmodule

// File: tb/tb_conv_layer_ctrl.sv
// Bench for conv_layer_ctrl: a default-sized instance driven by randomized
// handshake delays, plus a 1x1x1 instance for latency and watchdog edges.
`timescale 1ns/1ps
module tb_conv_layer_ctrl;
  localparam int B_IN  = 4;
  localparam int B_OUT = 8;
  localparam int B_POS = 16;
  localparam int B_TO  = 8;
  localparam int S_TO  = 4;
  localparam int RUN_BUDGET = 20000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  conv_layer_ctrl_if #(.IN_CH(B_IN), .OUT_CH(B_OUT), .NUM_POS(B_POS)) bb ();
  conv_layer_ctrl_if #(.IN_CH(1), .OUT_CH(1), .NUM_POS(1)) sb ();

  conv_layer_ctrl #(.IN_CH(B_IN), .OUT_CH(B_OUT), .NUM_POS(B_POS), .TIMEOUT(B_TO)) u_big (
    .clk(clk), .rst(rst), .bus(bb)
  );
  conv_layer_ctrl #(.IN_CH(1), .OUT_CH(1), .NUM_POS(1), .TIMEOUT(S_TO)) u_small (
    .clk(clk), .rst(rst), .bus(sb)
  );

  bit auto_en, block_in, glitch_en, mon_en;
  int dw, di, dc, dq;
  int exp_q[$];
  int out_q[$];
  int n_lw, n_conv, n_out, n_clr, n_last, n_done;
  bit lw_prev, out_prev;

  task automatic chk(string tag, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic bit big_wait();
    return bb.busy && !bb.load_weight_en && !bb.inputbuf_read_en &&
           !bb.conv33_en && !bb.output_en && !bb.done;
  endfunction

  function automatic int big_idx();
    return int'(bb.oc_idx) * 10000 + int'(bb.pos_idx) * 100 + int'(bb.ic_idx);
  endfunction

  function automatic int s_code();
    return int'({sb.done, sb.output_en, sb.conv33_en, sb.inputbuf_read_en, sb.load_weight_en});
  endfunction

  // compare the big instance against the loop-nest reference
  task automatic mon_big();
    int e;
    if (mon_en) begin
      if (bb.load_weight_en && !lw_prev) begin
        chk("lw_oc", int'(bb.oc_idx), n_lw);
        chk("lw_pos", int'(bb.pos_idx), 0);
        n_lw++;
      end
      if (bb.load_weight_en)
        chk("rd_w", int'(bb.read_weight_en), int'(bb.weight_load_done));
      if (bb.conv33_en) begin
        n_conv++;
        if (exp_q.size() == 0) chk("conv_extra", n_conv, 0);
        else begin
          e = exp_q.pop_front();
          chk("conv_idx", big_idx(), e);
          chk("acc_clear", int'(bb.acc_clear), int'((e % 100) == 0));
          chk("acc_last", int'(bb.acc_last), int'((e % 100) == B_IN - 1));
        end
      end
      if (bb.acc_clear) n_clr++;
      if (bb.acc_last) n_last++;
      if (bb.output_en && !out_prev) begin
        n_out++;
        if (out_q.size() == 0) chk("out_extra", n_out, 0);
        else chk("out_idx", big_idx(), out_q.pop_front());
      end
      if (bb.done) n_done++;
    end
    lw_prev  = bb.load_weight_en;
    out_prev = bb.output_en;
  endtask

  // randomized handshake responders for the big instance
  task automatic drive_big();
    bb.start = 1'b0;
    if (!auto_en) begin
      bb.weight_load_done = 1'b0;
      bb.input_ready      = 1'b0;
      bb.calc_valid       = 1'b0;
      bb.output_done      = 1'b0;
      return;
    end
    if (bb.load_weight_en) begin
      if (!bb.weight_load_done) begin
        if (dw == 0) bb.weight_load_done = 1'b1; else dw--;
      end
    end else begin
      bb.weight_load_done = 1'b0; dw = int'($urandom_range(0, 5));
    end
    if (bb.inputbuf_read_en && !block_in) begin
      if (!bb.input_ready) begin
        if (di == 0) bb.input_ready = 1'b1; else di--;
      end
    end else begin
      bb.input_ready = 1'b0; di = int'($urandom_range(0, 5));
    end
    if (big_wait()) begin
      if (!bb.calc_valid) begin
        if (dc == 0) bb.calc_valid = 1'b1; else dc--;
      end
    end else begin
      bb.calc_valid = 1'b0; dc = int'($urandom_range(0, 5));
    end
    if (bb.output_en) begin
      if (!bb.output_done) begin
        if (dq == 0) bb.output_done = 1'b1; else dq--;
      end
    end else begin
      bb.output_done = 1'b0; dq = int'($urandom_range(0, 5));
    end
    if (glitch_en && (big_wait() || bb.output_en) && ($urandom_range(0, 2) == 0))
      bb.start = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    mon_big();
    drive_big();
  endtask

  task automatic start_big();
    bb.start = 1'b1;
    step();
  endtask

  task automatic run_big(bit glitch);
    int budget;
    exp_q.delete();
    out_q.delete();
    for (int oc = 0; oc < B_OUT; oc++)
      for (int pos = 0; pos < B_POS; pos++) begin
        for (int ic = 0; ic < B_IN; ic++) exp_q.push_back(oc * 10000 + pos * 100 + ic);
        out_q.push_back(oc * 10000 + pos * 100);
      end
    n_lw = 0; n_conv = 0; n_out = 0; n_clr = 0; n_last = 0; n_done = 0;
    lw_prev = 1'b0; out_prev = 1'b0;
    auto_en = 1'b1; block_in = 1'b0; glitch_en = glitch; mon_en = 1'b1;
    start_big();
    chk("run_err_clr", int'(bb.error), 0);
    budget = 0;
    while (n_done == 0 && budget < RUN_BUDGET) begin
      step();
      budget++;
    end
    chk("run_budget", int'(budget < RUN_BUDGET), 1);
    step();
    step();
    glitch_en = 1'b0;
    chk("n_lw", n_lw, B_OUT);
    chk("n_conv", n_conv, B_OUT * B_POS * B_IN);
    chk("n_out", n_out, B_OUT * B_POS);
    chk("n_clr", n_clr, B_OUT * B_POS);
    chk("n_last", n_last, B_OUT * B_POS);
    chk("n_done", n_done, 1);
    chk("left_conv", exp_q.size(), 0);
    chk("end_busy", int'(bb.busy), 0);
    chk("end_idx", big_idx(), 0);
    chk("end_err", int'(bb.error), 0);
    mon_en = 1'b0;
    auto_en = 1'b0;
  endtask

  initial begin
    #5ms;
    $display("FAIL global_timeout got=1 exp=0");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int n, k;
    bit seen_done;
    int codes[6];
    codes = '{1, 2, 4, 0, 8, 16};
    auto_en = 1'b0; block_in = 1'b0; glitch_en = 1'b0; mon_en = 1'b0;
    bb.start = 1'b0; bb.weight_load_done = 1'b0; bb.input_ready = 1'b0;
    bb.calc_valid = 1'b0; bb.output_done = 1'b0;
    sb.start = 1'b0; sb.weight_load_done = 1'b0; sb.input_ready = 1'b0;
    sb.calc_valid = 1'b0; sb.output_done = 1'b0;

    // reset state
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("rst_busy", int'(bb.busy), 0);
    chk("rst_done", int'(bb.done), 0);
    chk("rst_err", int'(bb.error), 0);
    chk("rst_idx", big_idx(), 0);
    chk("rst_strobes", int'({bb.load_weight_en, bb.read_weight_en, bb.inputbuf_read_en,
                             bb.conv33_en, bb.acc_clear, bb.acc_last, bb.output_en}), 0);
    chk("rst_s_busy", int'(sb.busy), 0);

    // watchdog abort in LOAD_I on the big instance
    auto_en = 1'b1; block_in = 1'b1;
    start_big();
    n = 0; k = 0; seen_done = 1'b0;
    while (bb.busy && k < 100) begin
      if (bb.inputbuf_read_en) n++;
      if (bb.done) seen_done = 1'b1;
      step();
      k++;
    end
    chk("to_exit", int'(k < 100), 1);
    chk("to_cycles", n, B_TO);
    chk("to_err", int'(bb.error), 1);
    chk("to_done", int'(seen_done | bb.done), 0);
    chk("to_idx", big_idx(), 0);
    auto_en = 1'b0; block_in = 1'b0;
    step(); step();
    chk("err_hold", int'(bb.error), 1);

    // full layer with random delays; start clears the error
    run_big(1'b0);

    // synchronous reset in WAIT at oc=3, pos=5
    auto_en = 1'b1;
    start_big();
    k = 0;
    while (!(big_wait() && bb.oc_idx == 3 && bb.pos_idx == 5) && k < RUN_BUDGET) begin
      step();
      k++;
    end
    chk("rst_reach", int'(k < RUN_BUDGET), 1);
    rst = 1'b1; auto_en = 1'b0;
    step();
    chk("mid_rst_busy", int'(bb.busy), 0);
    chk("mid_rst_idx", big_idx(), 0);
    chk("mid_rst_done", int'(bb.done), 0);
    rst = 1'b0;
    step(); step();
    chk("mid_rst_quiet", int'(bb.busy | bb.done), 0);

    // full layer with start pulses during WAIT/OUTPUT
    run_big(1'b1);

    // small: watchdog abort after exactly S_TO WAIT cycles
    sb.weight_load_done = 1'b1; sb.input_ready = 1'b1; sb.output_done = 1'b1;
    sb.calc_valid = 1'b0;
    sb.start = 1'b1; step(); sb.start = 1'b0;
    repeat (3) step();
    chk("s_to_wait1", s_code(), 0);
    repeat (3) step();
    chk("s_to_wait4_busy", int'(sb.busy), 1);
    step();
    chk("s_to_idle", int'(sb.busy), 0);
    chk("s_to_err", int'(sb.error), 1);
    chk("s_to_done", int'(sb.done), 0);

    // small: state walk with all handshakes high
    sb.calc_valid = 1'b1;
    sb.start = 1'b1; step(); sb.start = 1'b0;
    chk("s1_err_clr", int'(sb.error), 0);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step();
      chk("s1_code", s_code(), codes[i]);
      chk("s1_busy", int'(sb.busy), 1);
      if (i == 0) chk("s1_rd_w", int'(sb.read_weight_en), 1);
      if (i == 2) chk("s1_clr_last", int'({sb.acc_clear, sb.acc_last}), 3);
    end
    step();
    chk("s1_idle", int'(sb.busy), 0);
    chk("s1_done_once", int'(sb.done), 0);

    // small: calc_valid on the last permitted WAIT cycle still advances
    sb.calc_valid = 1'b0;
    sb.start = 1'b1; step(); sb.start = 1'b0;
    repeat (6) step();
    chk("s6_wait4", s_code(), 0);
    sb.calc_valid = 1'b1;
    step();
    chk("s6_output", int'(sb.output_en), 1);
    chk("s6_err", int'(sb.error), 0);
    step();
    chk("s6_done", int'(sb.done), 1);
    step();
    chk("s6_idle", int'(sb.busy), 0);
    chk("s6_err_end", int'(sb.error), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
